// File: rtl/rot_regfile_scanner.sv
// Read-side sequencer for the rotating register file: walks address pairs,
// packs each pair into a byte and streams bytes through a 2-entry buffer.
module rot_regfile_scanner #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  output logic [ADDR_BITS-1:0]   r1_addr,
  output logic [ADDR_BITS-1:0]   r2_addr,
  input  logic [DATA_BITS-1:0]   rd_data1,
  input  logic [DATA_BITS-1:0]   rd_data2,
  output logic [2*DATA_BITS-1:0] byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = ADDR_BITS - 1;
  localparam int BW = 2 * DATA_BITS;
  localparam logic [PW-1:0] LAST_P = PW'(NUM_REGS / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [1:0]    count_q, count_d;
  logic [BW-1:0] head_q, head_d;
  logic [BW-1:0] tail_q, tail_d;
  logic          done_d;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic [ADDR_BITS-1:0] r1_q, r2_q;

  logic          pop_s;
  logic          space_s;
  logic          push_s;
  logic [BW-1:0] din_s;

  assign pop_s   = valid_q & byte_ready;
  assign space_s = (count_q != 2'd2) | pop_s;
  assign push_s  = (state_q == S_FETCH) & ~abort & space_s;
  assign din_s   = {rd_data2, rd_data1};

  // Sequencer: pair index walk, wrap/finish decision and drain completion.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      p_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          p_d = '0;
          if (start) state_d = S_FETCH;
          else       state_d = S_IDLE;
        end
        S_FETCH: begin
          if (space_s) begin
            if (p_q == LAST_P) begin
              p_d = '0;
              if (continuous) state_d = S_FETCH;
              else            state_d = S_DRAIN;
            end else begin
              p_d = p_q + PW'(1);
            end
          end else begin
            p_d = p_q;
          end
        end
        S_DRAIN: begin
          if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_s)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
          p_d     = '0;
        end
      endcase
    end
  end

  // Two-entry buffer: head is the presented byte and keeps its value when empty.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (abort) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) head_d = din_s;
          else                 tail_d = din_s;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          else                 head_d = head_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = din_s;
          end else begin
            head_d = tail_q;
            tail_d = din_s;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r1_q    <= '0;
      r2_q    <= {{PW{1'b0}}, 1'b1};
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (count_d != 2'd0);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      r1_q    <= {p_d, 1'b0};
      r2_q    <= {p_d, 1'b1};
    end
  end

  assign r1_addr    = r1_q;
  assign r2_addr    = r2_q;
  assign byte_data  = head_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/rot_regfile_scanner.md
Name: rot_regfile_scanner

Overview:
- Read-side sequencer for the baby VGA 16-entry, 4-bit rotating register file.
- Walks the file in address pairs (2p, 2p+1) on the file's two read ports.
- Packs each pair into one byte and delivers the bytes on a valid/ready stream to the downstream pixel/serializer stage.
- Supports single-pass, continuous and abort operation, with a 2-entry output buffer absorbing consumer stalls.

Parameters:
NUM_REGS, 16, number of register-file entries; must be even, >= 4
ADDR_BITS, 4, register-file address width; 2**ADDR_BITS >= NUM_REGS
DATA_BITS, 4, width of one register entry; byte width = 2*DATA_BITS

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a scan; sampled only in IDLE
continuous  input  1  level; when 1, wrap to pair 0 after the last pair instead of finishing
abort  input  1  synchronous stop; flush and return to IDLE
r1_addr  output  ADDR_BITS  read address to file port 1, always 2p
r2_addr  output  ADDR_BITS  read address to file port 2, always 2p+1
rd_data1  input  DATA_BITS  combinational read data for r1_addr
rd_data2  input  DATA_BITS  combinational read data for r2_addr
byte_data  output  2*DATA_BITS  head of output buffer, {rd_data2, rd_data1}
byte_valid  output  1  output buffer non-empty
byte_ready  input  1  consumer accepts byte_data when byte_valid&byte_ready
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on completion of a single-pass scan

Behaviour:
- Reset (async, rst=1): state IDLE, p=0, buffer empty.
  - Outputs during reset: r1_addr=0, r2_addr=1, byte_data=0, byte_valid=0, busy=0, done=0.
- Pair index p: width ADDR_BITS-1, range 0..NUM_REGS/2-1. r1_addr/r2_addr are registered functions of p, held while not capturing.
- Output buffer: 2-entry FIFO.
  - pop = byte_valid & byte_ready.
  - "space" = count<2 OR pop in the same cycle (simultaneous push+pop when full is legal).
- States:
  - IDLE: p=0. On a start edge with abort=0, go to FETCH. No capture in IDLE.
  - FETCH: on each edge with space, push {rd_data2, rd_data1}.
    - If p < NUM_REGS/2-1: increment p.
    - If p is the last pair and continuous=1: p<=0 and stay in FETCH. No gap; pair 0 is captured on the next edge.
    - If p is the last pair and continuous=0: p<=0 and go to DRAIN.
    - Without space, hold p with no push. rd_data is resampled on the next edge.
  - DRAIN: no pushes. When the buffer becomes empty (count reaches 0 via pop, or is already 0), go to IDLE and pulse done for exactly one cycle.
    - done is asserted in the cycle following the edge on which the last byte is popped.
- Latency:
  - start seen at edge T → FETCH from T+1.
  - Pair 0 captured at edge T+1 → byte_valid=1 after T+1.
  - With byte_ready held 1: one byte per cycle, NUM_REGS/2 bytes, done after edge T+NUM_REGS/2+1.
- Data coherence: each byte reflects the file contents at its capture edge. Writes to the file mid-scan are allowed and are not tracked; a write landing on the edge of capture is not visible until the following capture of that address.
- abort (any state): at the next edge go to IDLE, p=0, flush the buffer (byte_valid=0). done is not pulsed.
  - abort with start simultaneously: abort wins, stays IDLE.
- start while busy: ignored. Changing continuous mid-scan takes effect at the next last-pair capture.
- byte_data when empty: holds its last value (0 after reset). Consumers must qualify it with byte_valid.
- Asserting rst mid-scan returns everything to reset values immediately. Buffer contents are lost.

Test Plan:
- Reset/idle: hold rst=1 then release with no start → r1_addr=0, r2_addr=1, byte_valid=0, busy=0, done=0 indefinitely.
- Single pass, ready=1: file preloaded with entry i = i (mod 16); start pulse → bytes 0x10, 0x32, 0x54, 0x76, 0x98, 0xBA, 0xDC, 0xFE on 8 consecutive cycles; done pulses once in the cycle after the 8th byte; busy then 0.
- Backpressure: same preload; byte_ready=0 for 5 cycles after start → exactly 2 bytes buffered (0x10, 0x32); r1_addr stalls at 4; release ready → all 8 bytes in order, none duplicated or dropped.
- Continuous: continuous=1, start → after 0xFE the next byte is 0x10 with no idle cycle; no done. Drop continuous during pair 5 → the pass ends after 0xFE and done pulses.
- Abort: abort at the 3rd byte with ready toggling → byte_valid=0 and busy=0 next cycle, no done. A start+abort in the same cycle stays in IDLE.
- Mid-scan write: write entry 7 = 0x0 while p=1 → byte 4 is 0x06. Async rst asserted mid-scan → outputs return to reset values without waiting for a clock edge.
